// File: rtl/game_pkg.sv
// Shared definitions for the memory-sequence game controller.
//   - state encodings and state width
//   - command-vector bit positions (R1, R2, E1..E4, SEL)
//   - key/switch counts shared with the Datapath
//   - cmd_decode(): the Moore output decode, state -> command vector
package game_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_INIT       = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP      = 3'd1;
  localparam logic [ST_W-1:0] ST_PLAY_FPGA  = 3'd2;
  localparam logic [ST_W-1:0] ST_PLAY_USER  = 3'd3;
  localparam logic [ST_W-1:0] ST_CHECK      = 3'd4;
  localparam logic [ST_W-1:0] ST_NEXT_ROUND = 3'd5;
  localparam logic [ST_W-1:0] ST_RESULT     = 3'd6;

  localparam int CMD_W   = 7;
  localparam int CMD_R1  = 0;
  localparam int CMD_R2  = 1;
  localparam int CMD_E1  = 2;
  localparam int CMD_E2  = 3;
  localparam int CMD_E3  = 4;
  localparam int CMD_E4  = 5;
  localparam int CMD_SEL = 6;

  localparam int P_KEY    = 4;
  localparam int P_SWITCH = 8;

  // Encoding 7 decodes to nothing active; the FSM leaves it on the next edge.
  function automatic logic [CMD_W-1:0] cmd_decode(input logic [ST_W-1:0] st);
    logic [CMD_W-1:0] cmd;
    cmd = '0;
    case (st)
      ST_INIT: begin
        cmd[CMD_R1] = 1'b1;
        cmd[CMD_R2] = 1'b1;
      end
      ST_SETUP:      cmd[CMD_E1] = 1'b1;
      ST_PLAY_FPGA:  cmd[CMD_E2] = 1'b1;
      ST_PLAY_USER:  cmd[CMD_E3] = 1'b1;
      ST_NEXT_ROUND: begin
        cmd[CMD_R2] = 1'b1;
        cmd[CMD_E4] = 1'b1;
      end
      ST_RESULT:     cmd[CMD_SEL] = 1'b1;
      default:       cmd = '0;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer plus rise detector for an asynchronous key level.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   i_key    asynchronous active-high key level
//   o_rise   one-cycle pulse on a synchronized 0->1 transition
// All flops reset to 1 so a key held through reset is not seen as a press
// until it has been released and pressed again.
module key_edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/game_controller.sv
// Control FSM for the memory-sequence game (Moore machine).
// Ports:
//   CLOCK_50                      system clock
//   reset                         synchronous active-high reset
//   enter                         asynchronous player confirm key
//   end_FPGA/end_User/end_time    Datapath status flags
//   win/match                     round result flags from the Datapath
//   R1, R2, E1..E4, SEL           Datapath command lines (state decode only)
//   state_dbg                     current state encoding
//
// state      | meaning
// INIT       | clear setup/level and round registers
// SETUP      | load setup registers, wait for enter
// PLAY_FPGA  | Datapath shows the sequence
// PLAY_USER  | capture player input until done or timed out
// CHECK      | one-cycle decision on match/win
// NEXT_ROUND | clear round-local state, bump the round
// RESULT     | show result until enter or result timer expiry
module game_controller
  import game_pkg::*;
#(
  parameter int RESULT_TIMEOUT = 0,
  parameter int TIMEOUT_W      = 28
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state_dbg
);

  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(RESULT_TIMEOUT - 1);

  logic [ST_W-1:0]      r_state;
  logic [ST_W-1:0]      w_state_next;
  logic [CMD_W-1:0]     w_cmd;
  logic [TIMEOUT_W-1:0] r_timer;
  logic                 w_enter_rise;
  logic                 w_timeout_hit;

  key_edge_sync u_enter_sync (
    .i_clk   (CLOCK_50),
    .i_reset (reset),
    .i_key   (enter),
    .o_rise  (w_enter_rise)
  );

  // Timer sits at 0 outside RESULT, so it is already cleared on entry.
  always_ff @(posedge CLOCK_50) begin
    if (reset || (r_state != ST_RESULT)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIMEOUT_W'(1);
    end
  end

  assign w_timeout_hit = (RESULT_TIMEOUT != 0) && (r_timer == TIMER_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT:      w_state_next = ST_SETUP;
      ST_SETUP:     if (w_enter_rise) w_state_next = ST_PLAY_FPGA;
      ST_PLAY_FPGA: if (end_FPGA) w_state_next = ST_PLAY_USER;
      ST_PLAY_USER: begin
        if (end_time) begin
          w_state_next = ST_RESULT;
        end else if (end_User) begin
          w_state_next = ST_CHECK;
        end
      end
      // A mismatch ends the game even if win is also raised.
      ST_CHECK: begin
        if (!match || win) begin
          w_state_next = ST_RESULT;
        end else begin
          w_state_next = ST_NEXT_ROUND;
        end
      end
      ST_NEXT_ROUND: w_state_next = ST_PLAY_FPGA;
      ST_RESULT:     if (w_enter_rise || w_timeout_hit) w_state_next = ST_INIT;
      default:       w_state_next = ST_INIT;
    endcase
  end

  always_comb begin
    w_cmd = cmd_decode(r_state);
  end

  assign R1        = w_cmd[CMD_R1];
  assign R2        = w_cmd[CMD_R2];
  assign E1        = w_cmd[CMD_E1];
  assign E2        = w_cmd[CMD_E2];
  assign E3        = w_cmd[CMD_E3];
  assign E4        = w_cmd[CMD_E4];
  assign SEL       = w_cmd[CMD_SEL];
  assign state_dbg = r_state;

endmodule
